// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard
//   Hazard and forwarding scoreboard for the in-order pipeline. Tracks the
//   destinations of instructions in the DEPTH stages after ID. Checks the ID
//   sources against them, raises a combinational stall, and registers the
//   forwarding selects so they are valid while the consumer sits in EXE.
//
// Ports
//   clk, rst            clock (rising edge), async active-high reset
//   fwd_en              0 = every RAW dependence stalls
//   freeze              hold all state and registered outputs
//   flush               kill the instruction currently in ID
//   id_*                ID-stage instruction: sources, dest, wb/load flags
//   stall               combinational: hold IF/ID, insert a bubble
//   exe_sel_src1/2      0 = regfile, k = forward from stage index k
//   exe_forwarded       either select non-zero
//   inflight            bit r set if a valid entry below WB writes r
//   stall_count         saturating count of stall cycles
module pipe_scoreboard #(
  parameter int REG_W      = 4,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = $clog2(DEPTH),
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fwd_en,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [REG_W-1:0]      id_src1,
  input  logic [REG_W-1:0]      id_src2,
  input  logic                  id_src1_en,
  input  logic                  id_src2_en,
  input  logic [REG_W-1:0]      id_dest,
  input  logic                  id_wb_en,
  input  logic                  id_mem_r_en,
  output logic                  stall,
  output logic [SEL_W-1:0]      exe_sel_src1,
  output logic [SEL_W-1:0]      exe_sel_src2,
  output logic                  exe_forwarded,
  output logic [2**REG_W-1:0]   inflight,
  output logic [CNT_W-1:0]      stall_count
);

  // Entry state, index 0 = EXE ... DEPTH-1 = WB
  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [DEPTH-1:0]            ld_q, ld_d;
  logic [DEPTH-1:0][REG_W-1:0] dest_q, dest_d;

  logic [SEL_W-1:0] sel1_q, sel1_d, sel2_q, sel2_d;
  logic             fwd_q, fwd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DEPTH-1:0] m1, m2, fwdok;
  logic [SEL_W-1:0] sel1, sel2;
  logic             hz1, hz2, issue, push_v;

  // Per-entry match / forwardability. The WB entry is never matched: the
  // regfile writes in the first half-cycle and ID reads in the second.
  always_comb begin
    m1 = '0;
    m2 = '0;
    fwdok = '0;
    for (int i = 0; i < DEPTH-1; i++) begin
      m1[i]    = vld_q[i] && (dest_q[i] == id_src1) && id_src1_en;
      m2[i]    = vld_q[i] && (dest_q[i] == id_src2) && id_src2_en;
      // consumer reaches EXE when the producer reaches i+1
      fwdok[i] = fwd_en && !(ld_q[i] && (i+1 < LOAD_STAGE));
    end
  end

  // Walk oldest to youngest so the youngest match's select wins.
  always_comb begin
    sel1 = '0;
    sel2 = '0;
    hz1  = 1'b0;
    hz2  = 1'b0;
    inflight = '0;
    for (int i = DEPTH-2; i >= 0; i--) begin
      if (m1[i]) sel1 = fwd_en ? SEL_W'(i+1) : '0;
      if (m2[i]) sel2 = fwd_en ? SEL_W'(i+1) : '0;
      if (m1[i] && !fwdok[i]) hz1 = 1'b1;
      if (m2[i] && !fwdok[i]) hz2 = 1'b1;
      if (vld_q[i]) inflight[dest_q[i]] = 1'b1;
    end
  end

  assign stall  = id_valid && !flush && (hz1 || hz2);
  assign issue  = id_valid && !stall && !flush;
  assign push_v = issue && id_wb_en;

  always_comb begin
    vld_d  = vld_q;
    ld_d   = ld_q;
    dest_d = dest_q;
    sel1_d = sel1_q;
    sel2_d = sel2_q;
    fwd_d  = fwd_q;
    cnt_d  = cnt_q;
    if (!freeze) begin
      vld_d  = {vld_q[DEPTH-2:0], push_v};
      ld_d   = {ld_q[DEPTH-2:0], push_v && id_mem_r_en};
      dest_d = {dest_q[DEPTH-2:0], id_dest};
      sel1_d = issue ? sel1 : '0;
      sel2_d = issue ? sel2 : '0;
      fwd_d  = issue && ((sel1 != '0) || (sel2 != '0));
      if (stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      ld_q   <= '0;
      dest_q <= '0;
      sel1_q <= '0;
      sel2_q <= '0;
      fwd_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      ld_q   <= ld_d;
      dest_q <= dest_d;
      sel1_q <= sel1_d;
      sel2_q <= sel2_d;
      fwd_q  <= fwd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign exe_sel_src1  = sel1_q;
  assign exe_sel_src2  = sel2_q;
  assign exe_forwarded = fwd_q;
  assign stall_count   = cnt_q;

endmodule

// File: tb/tb_pipe_scoreboard.sv
module tb_pipe_scoreboard;
  logic        clk = 1'b0;
  logic        rst, fwd_en, freeze, flush, id_valid;
  logic [3:0]  id_src1, id_src2, id_dest;
  logic        id_src1_en, id_src2_en, id_wb_en, id_mem_r_en;
  logic        stall, exe_forwarded;
  logic [1:0]  exe_sel_src1, exe_sel_src2;
  logic [15:0] inflight;
  logic [31:0] stall_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_scoreboard dut (
    .clk(clk), .rst(rst), .fwd_en(fwd_en), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_en(id_src1_en), .id_src2_en(id_src2_en), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .stall(stall),
    .exe_sel_src1(exe_sel_src1), .exe_sel_src2(exe_sel_src2),
    .exe_forwarded(exe_forwarded), .inflight(inflight),
    .stall_count(stall_count)
  );

  typedef struct {
    logic        fwd, fl;
    logic [3:0]  s1;
    logic        s1e;
    logic [3:0]  s2;
    logic        s2e;
    logic [3:0]  dst;
    logic        wb, ld;
    logic        e_stall;   // before the edge
    logic [15:0] e_infl;    // before the edge
    logic [1:0]  e_s1, e_s2;  // after the edge
    logic        e_fwd;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input int fwd, fl, s1, s1e, s2, s2e, dst, wb, ld,
                              st, infl, e1, e2, ef, cnt);
    vec_t v;
    v.fwd = 1'(fwd);  v.fl = 1'(fl);
    v.s1 = 4'(s1);    v.s1e = 1'(s1e);
    v.s2 = 4'(s2);    v.s2e = 1'(s2e);
    v.dst = 4'(dst);  v.wb = 1'(wb);  v.ld = 1'(ld);
    v.e_stall = 1'(st); v.e_infl = 16'(infl);
    v.e_s1 = 2'(e1);  v.e_s2 = 2'(e2);  v.e_fwd = 1'(ef);
    v.e_cnt = 32'(cnt);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    fwd_en = v.fwd; flush = v.fl; id_valid = 1'b1;
    id_src1 = v.s1; id_src1_en = v.s1e;
    id_src2 = v.s2; id_src2_en = v.s2e;
    id_dest = v.dst; id_wb_en = v.wb; id_mem_r_en = v.ld;
  endtask

  task automatic instr(input int fwd, s1, s1e, s2, s2e, dst, ld);
    drive(mk(fwd, 0, s1, s1e, s2, s2e, dst, 1, ld, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    rst = 1'b1; fwd_en = 1'b1; freeze = 1'b0; flush = 1'b0; id_valid = 1'b0;
    id_src1 = '0; id_src2 = '0; id_dest = '0;
    id_src1_en = 1'b0; id_src2_en = 1'b0; id_wb_en = 1'b0; id_mem_r_en = 1'b0;

    //            fwd fl s1 e  s2 e dst wb ld  stall infl     s1 s2 f cnt
    vecs[0]  = mk(1, 0,  0, 0,  0, 0, 1, 1, 0,  0, 'h0000,  0, 0, 0, 0); // ADD r1
    vecs[1]  = mk(1, 0,  1, 1,  3, 1, 2, 1, 0,  0, 'h0002,  1, 0, 1, 0); // SUB r2,r1,r3
    vecs[2]  = mk(1, 0, 13, 1,  0, 0, 4, 1, 1,  0, 'h0006,  0, 0, 0, 0); // LDR r4
    vecs[3]  = mk(1, 0,  4, 1,  4, 1, 5, 1, 0,  1, 'h0014,  0, 0, 0, 1); // ADD r5,r4,r4 stall
    vecs[4]  = mk(1, 0,  4, 1,  4, 1, 5, 1, 0,  0, 'h0010,  2, 2, 1, 1); // issues, sel=2
    vecs[5]  = mk(0, 0,  0, 0,  0, 0, 1, 1, 0,  0, 'h0020,  0, 0, 0, 1); // ADD r1, fwd off
    vecs[6]  = mk(0, 0,  1, 1,  0, 0, 6, 1, 0,  1, 'h0022,  0, 0, 0, 2); // ORR r6,r1
    vecs[7]  = mk(0, 0,  1, 1,  0, 0, 6, 1, 0,  1, 'h0002,  0, 0, 0, 3);
    vecs[8]  = mk(0, 0,  1, 1,  0, 0, 6, 1, 0,  0, 'h0000,  0, 0, 0, 3); // r1 in WB
    vecs[9]  = mk(1, 0,  0, 0,  0, 0, 7, 1, 0,  0, 'h0040,  0, 0, 0, 3); // MOV r7
    vecs[10] = mk(1, 0,  0, 0,  0, 0, 7, 1, 0,  0, 'h00C0,  0, 0, 0, 3); // MOV r7
    vecs[11] = mk(1, 0,  7, 1,  6, 1, 8, 1, 0,  0, 'h0080,  1, 0, 1, 3); // youngest, r6 in WB

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_sel1", 32'(exe_sel_src1), 0);
    chk("rst_sel2", 32'(exe_sel_src2), 0);
    chk("rst_fwd", 32'(exe_forwarded), 0);
    chk("rst_cnt", stall_count, 0);
    chk("rst_infl", 32'(inflight), 0);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d_infl", i), 32'(inflight), 32'(vecs[i].e_infl));
      @(posedge clk); #1;
      chk($sformatf("v%0d_sel1", i), 32'(exe_sel_src1), 32'(vecs[i].e_s1));
      chk($sformatf("v%0d_sel2", i), 32'(exe_sel_src2), 32'(vecs[i].e_s2));
      chk($sformatf("v%0d_fwd", i), 32'(exe_forwarded), 32'(vecs[i].e_fwd));
      chk($sformatf("v%0d_cnt", i), stall_count, vecs[i].e_cnt);
    end

    // Flush during a load-use stall. Entries now: r8, r7, r7.
    instr(1, 0, 0, 0, 0, 9, 1);             // LDR r9
    @(negedge clk); chk("ldr9_stall", 32'(stall), 0);
    @(posedge clk); #1;
    instr(1, 9, 1, 0, 0, 10, 0);            // ADD r10,r9
    @(negedge clk); chk("lu_stall", 32'(stall), 1);
    #1 flush = 1'b1;
    #1 chk("flush_stall", 32'(stall), 0);
    @(posedge clk); #1;
    chk("flush_cnt", stall_count, 3);
    chk("flush_sel1", 32'(exe_sel_src1), 0);
    chk("flush_fwd", 32'(exe_forwarded), 0);
    chk("flush_infl", 32'(inflight), 'h0200);  // bubble, r9, r8 (WB)
    flush = 1'b0;

    // Load now at MEM: forwardable with sel=2.
    instr(1, 9, 1, 0, 0, 11, 0);            // ADD r11,r9
    @(negedge clk); chk("lu2_stall", 32'(stall), 0);
    @(posedge clk); #1;
    chk("lu2_sel1", 32'(exe_sel_src1), 2);
    chk("lu2_fwd", 32'(exe_forwarded), 1);

    // Freeze for 3 cycles with a stalling consumer; last cycle adds flush.
    instr(0, 11, 1, 0, 0, 12, 0);
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      flush = (k == 2);
      @(negedge clk);
      if (k < 2) chk($sformatf("frz%0d_stall", k), 32'(stall), 1);
      @(posedge clk); #1;
      chk($sformatf("frz%0d_infl", k), 32'(inflight), 'h0800);
      chk($sformatf("frz%0d_sel1", k), 32'(exe_sel_src1), 2);
      chk($sformatf("frz%0d_fwd", k), 32'(exe_forwarded), 1);
      chk($sformatf("frz%0d_cnt", k), stall_count, 3);
    end
    freeze = 1'b0; flush = 1'b0; fwd_en = 1'b1;
    @(negedge clk); chk("unfrz_stall", 32'(stall), 0);
    @(posedge clk); #1;
    chk("unfrz_sel1", 32'(exe_sel_src1), 1);
    chk("unfrz_cnt", stall_count, 3);

    // Mid-stream reset with r12, r11 in flight.
    id_valid = 1'b0;
    @(negedge clk); chk("pre_rst_infl", 32'(inflight), 'h1800);
    #1 rst = 1'b1;
    #1;
    chk("mrst_infl", 32'(inflight), 0);
    chk("mrst_sel1", 32'(exe_sel_src1), 0);
    chk("mrst_fwd", 32'(exe_forwarded), 0);
    chk("mrst_cnt", stall_count, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    instr(1, 12, 1, 11, 1, 13, 0);
    @(negedge clk); chk("post_rst_stall", 32'(stall), 0);
    @(posedge clk); #1;
    chk("post_rst_sel1", 32'(exe_sel_src1), 0);
    chk("post_rst_sel2", 32'(exe_sel_src2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
